uart_rx_fifo: RTL and testbench

//  UART receiver with a runtime-programmable baud divider, optional parity, one or two

---
 rtl/uart_rx_fifo.sv | 239 +++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with a runtime baud divider, optional even/odd parity and one
//   or two stop bits, feeding a small first-word-fall-through receive FIFO.
//   Each FIFO entry carries the data byte plus a bad-parity flag. Framing and
//   overrun errors are sticky until err_clear. RTS (active low) is driven from
//   FIFO occupancy.
//
// Handshake: rx_valid means the head entry (rx_data, rx_parity_err) is valid;
//   the entry is consumed on a clock edge where rx_read && rx_valid. rx_read
//   with rx_valid low is ignored.
//
// Ports
//   clk, resetn        clock, synchronous active-low reset
//   uart_rxd           asynchronous serial input, idle high
//   uart_rts           RTS, 0 = ready to receive, 1 = FIFO nearly full
//   cfg_divider        clocks per bit minus 1 (>= 3), latched at frame start
//   cfg_parity_en/odd  parity enable and odd/even select, latched at frame start
//   cfg_two_stop       check two stop bits, latched at frame start
//   rx_read            pop the head entry
//   rx_valid/rx_data/rx_parity_err/rx_level   FIFO head and occupancy
//   err_frame/err_overrun/err_clear           sticky error flags and clear
//   dbg_state          receiver FSM state
module uart_rx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DIV_WIDTH    = 13,
    parameter int DIV_RESET    = 6666,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          uart_rxd,
    output logic                          uart_rts,
    input  logic [DIV_WIDTH-1:0]          cfg_divider,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_two_stop,
    input  logic                          rx_read,
    output logic                          rx_valid,
    output logic [PAYLOAD_BITS-1:0]       rx_data,
    output logic                          rx_parity_err,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          err_frame,
    output logic                          err_overrun,
    input  logic                          err_clear,
    output logic [2:0]                    dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int IDX_W = $clog2(PAYLOAD_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_RTS  = LVL_W'(FIFO_DEPTH - 1);

    // The software default divider must fit the divider port.
    if (DIV_RESET >= (1 << DIV_WIDTH)) begin : g_div_reset_too_wide
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5,
        S_BREAK  = 3'd6
    } state_t;

    state_t                  r_state, w_next;
    logic                    r_rxd_meta, r_rxd_sync;
    logic                    w_rxd;
    logic [DIV_WIDTH-1:0]    r_div, r_cnt;
    logic                    r_par_en, r_par_odd, r_two_stop;
    logic [IDX_W-1:0]        r_bit_idx;
    logic [PAYLOAD_BITS-1:0] r_shift;
    logic                    r_par;
    logic                    w_mid, w_end;
    logic                    w_push, w_frame_err, w_parity_err;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= uart_rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end
    assign w_rxd = r_rxd_sync;

    assign w_mid = (r_cnt == (r_div >> 1));
    assign w_end = (r_cnt == r_div);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_push      = 1'b0;
        w_frame_err = 1'b0;
        case (r_state)
            S_IDLE:   if (!w_rxd) w_next = S_START;
            S_START: begin
                if (w_mid && w_rxd) w_next = S_IDLE;   // glitch, not a real start bit
                else if (w_end)     w_next = S_DATA;
            end
            S_DATA: begin
                if (w_end && (r_bit_idx == LAST_IDX))
                    w_next = r_par_en ? S_PARITY : S_STOP1;
            end
            S_PARITY: if (w_end) w_next = S_STOP1;
            S_STOP1: begin
                if (w_mid) begin
                    if (!w_rxd) begin
                        w_frame_err = 1'b1;
                        w_next      = S_BREAK;
                    end else if (!r_two_stop) begin
                        // Return to IDLE at mid-stop so the next start edge is caught early.
                        w_push = 1'b1;
                        w_next = S_IDLE;
                    end
                end else if (w_end) begin
                    w_next = S_STOP2;
                end
            end
            S_STOP2: begin
                if (w_mid) begin
                    if (w_rxd) begin
                        w_push = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_frame_err = 1'b1;
                        w_next      = S_BREAK;
                    end
                end
            end
            S_BREAK:  if (w_rxd) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Bit timer, frame configuration and shift register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_par_en   <= 1'b0;
            r_par_odd  <= 1'b0;
            r_two_stop <= 1'b0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
        end else begin
            if (r_state == S_IDLE && !w_rxd) begin
                r_div      <= cfg_divider;
                r_par_en   <= cfg_parity_en;
                r_par_odd  <= cfg_parity_odd;
                r_two_stop <= cfg_two_stop;
            end
            if (r_state == S_IDLE || r_state == S_BREAK || w_end) r_cnt <= '0;
            else                                                   r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_START: begin
                    r_bit_idx <= '0;
                    r_par     <= 1'b0;
                end
                S_DATA: begin
                    if (w_mid) begin
                        r_shift <= {w_rxd, r_shift[PAYLOAD_BITS-1:1]};  // LSB first
                        r_par   <= r_par ^ w_rxd;
                    end
                    if (w_end) r_bit_idx <= r_bit_idx + 1'b1;
                end
                S_PARITY: if (w_mid) r_par <= r_par ^ w_rxd;
                default: ;
            endcase
        end
    end

    // r_par holds XOR of data and parity bit; even wants 0, odd wants 1.
    assign w_parity_err = r_par_en & (r_par ^ r_par_odd);

    // Receive FIFO: entry = {parity_err, data}.
    logic [PAYLOAD_BITS:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr, r_rd_ptr;
    logic [LVL_W-1:0]      r_level;
    logic                  r_rts, r_err_frame, r_err_overrun;
    logic                  w_pop, w_full, w_wr, w_overrun;
    logic [PAYLOAD_BITS:0] w_head;

    assign w_pop     = rx_read && (r_level != '0);
    assign w_full    = (r_level == LVL_FULL);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign w_wr      = w_push && (!w_full || w_pop);
    assign w_overrun = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= {w_parity_err, r_shift};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_rts         <= 1'b1;
            r_err_frame   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            r_rts <= (r_level >= LVL_RTS);
            // Set events take priority over err_clear.
            if (w_frame_err)    r_err_frame <= 1'b1;
            else if (err_clear) r_err_frame <= 1'b0;
            if (w_overrun)      r_err_overrun <= 1'b1;
            else if (err_clear) r_err_overrun <= 1'b0;
        end
    end

    assign w_head        = r_mem[r_rd_ptr];
    assign rx_valid      = (r_level != '0);
    assign rx_data       = rx_valid ? w_head[PAYLOAD_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid ? w_head[PAYLOAD_BITS] : 1'b0;
    assign rx_level      = r_level;
    assign uart_rts      = r_rts;
    assign err_frame     = r_err_frame;
    assign err_overrun   = r_err_overrun;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo: serial frames are driven bit by bit at
//   div=15 (16 clocks per bit) and the FIFO head, level, RTS and error flags
//   are compared against hand-computed values.
module tb_uart_rx_fifo;

    localparam int BIT_CYC = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        uart_rxd = 1'b1;
    logic        uart_rts;
    logic [12:0] cfg_divider = 13'd15;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_two_stop = 1'b0;
    logic        rx_read = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_parity_err;
    logic [2:0]  rx_level;
    logic        err_frame;
    logic        err_overrun;
    logic        err_clear = 1'b0;
    logic [2:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    uart_rx_fifo #(.PAYLOAD_BITS(8), .DIV_WIDTH(13), .DIV_RESET(6666), .FIFO_DEPTH(4)) dut (
        .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rts(uart_rts),
        .cfg_divider(cfg_divider), .cfg_parity_en(cfg_parity_en),
        .cfg_parity_odd(cfg_parity_odd), .cfg_two_stop(cfg_two_stop),
        .rx_read(rx_read), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_parity_err(rx_parity_err), .rx_level(rx_level),
        .err_frame(err_frame), .err_overrun(err_overrun), .err_clear(err_clear),
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete, time=%0t limit=2ms", $time);
        $fatal(1, "watchdog");
    end

    // Driver tasks (all driving happens on the falling edge)
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v);
        uart_rxd = v;
        repeat (BIT_CYC) @(negedge clk);
    endtask

    // Start bit goes out on the first falling edge after the call. The line is
    // left at the value of the last stop bit.
    task automatic send_frame(input logic [7:0] data, input logic par_en,
                              input logic par_bit, input int n_stop, input logic stop_val);
        @(negedge clk);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        if (par_en) drive_bit(par_bit);
        drive_bit(stop_val);
        for (int i = 1; i < n_stop; i++) drive_bit(1'b1);
    endtask

    task automatic pop_byte();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
    endtask

    // Scenario tasks
    task automatic test_reset();
        resetn = 1'b0;
        idle(3);
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rx_data); end
        n_tests++; if (rx_level !== 3'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", rx_level); end
        n_tests++; if (uart_rts !== 1'b1) begin n_fail++; $display("FAIL reset_rts got=%b exp=1", uart_rts); end
        n_tests++; if ({err_frame, err_overrun} !== 2'b00) begin n_fail++; $display("FAIL reset_err got=%b exp=00", {err_frame, err_overrun}); end
        n_tests++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        resetn = 1'b1;
        idle(8);
    endtask

    task automatic test_basic();
        cfg_divider = 13'd15; cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", rx_valid); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL basic_data got=%h exp=a5", rx_data); end
        n_tests++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL basic_perr got=%b exp=0", rx_parity_err); end
        n_tests++; if (rx_level !== 3'd1) begin n_fail++; $display("FAIL basic_level got=%0d exp=1", rx_level); end
        pop_byte();
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_valid got=%b exp=0", rx_valid); end
        n_tests++; if (rx_level !== 3'd0) begin n_fail++; $display("FAIL basic_pop_level got=%0d exp=0", rx_level); end
        // Two stop bits
        cfg_two_stop = 1'b1;
        send_frame(8'h5A, 1'b0, 1'b0, 2, 1'b1);
        idle(4);
        cfg_two_stop = 1'b0;
        n_tests++; if (rx_data !== 8'h5A || rx_level !== 3'd1) begin n_fail++; $display("FAIL two_stop got=%h/%0d exp=5a/1", rx_data, rx_level); end
        n_tests++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL two_stop_frame got=%b exp=0", err_frame); end
        pop_byte();
    endtask

    task automatic test_parity();
        logic [2:0] vec [4];  // {odd, parity bit, expected error}
        vec[0] = 3'b000; vec[1] = 3'b011; vec[2] = 3'b101; vec[3] = 3'b110;
        cfg_parity_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cfg_parity_odd = vec[i][2];
            send_frame(8'h03, 1'b1, vec[i][1], 1, 1'b1);
            idle(4);
            n_tests++; if (rx_data !== 8'h03 || rx_valid !== 1'b1) begin n_fail++; $display("FAIL parity_data[%0d] got=%h/%b exp=03/1", i, rx_data, rx_valid); end
            n_tests++; if (rx_parity_err !== vec[i][0]) begin n_fail++; $display("FAIL parity_err[%0d] got=%b exp=%b", i, rx_parity_err, vec[i][0]); end
            pop_byte();
        end
        cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;
    endtask

    task automatic test_frame_break();
        send_frame(8'h55, 1'b0, 1'b0, 1, 1'b0);
        idle(4);
        n_tests++; if (err_frame !== 1'b1) begin n_fail++; $display("FAIL frame_err got=%b exp=1", err_frame); end
        n_tests++; if (rx_level !== 3'd0) begin n_fail++; $display("FAIL frame_nopush got=%0d exp=0", rx_level); end
        idle(50 * BIT_CYC);
        n_tests++; if (rx_level !== 3'd0) begin n_fail++; $display("FAIL break_nopush got=%0d exp=0", rx_level); end
        n_tests++; if (dbg_state !== 3'd6) begin n_fail++; $display("FAIL break_state got=%0d exp=6", dbg_state); end
        uart_rxd = 1'b1;
        idle(4 * BIT_CYC);
        send_frame(8'h12, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        n_tests++; if (rx_data !== 8'h12 || rx_level !== 3'd1) begin n_fail++; $display("FAIL after_break got=%h/%0d exp=12/1", rx_data, rx_level); end
        pop_byte();
        pulse_clear();
        n_tests++; if (err_frame !== 1'b0) begin n_fail++; $display("FAIL frame_clear got=%b exp=0", err_frame); end
    endtask

    task automatic test_overrun();
        logic [2:0] exp_lvl;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'(i + 1), 1'b0, 1'b0, 1, 1'b1);
            idle(4);
            exp_lvl = (i < 4) ? 3'(i + 1) : 3'd4;
            n_tests++; if (rx_level !== exp_lvl) begin n_fail++; $display("FAIL ovr_level[%0d] got=%0d exp=%0d", i, rx_level, exp_lvl); end
            n_tests++; if (uart_rts !== (exp_lvl >= 3'd3)) begin n_fail++; $display("FAIL ovr_rts[%0d] got=%b exp=%b", i, uart_rts, exp_lvl >= 3'd3); end
            n_tests++; if (err_overrun !== (i == 4)) begin n_fail++; $display("FAIL ovr_flag[%0d] got=%b exp=%b", i, err_overrun, i == 4); end
        end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rx_data !== 8'(i + 1)) begin n_fail++; $display("FAIL ovr_pop[%0d] got=%h exp=%h", i, rx_data, 8'(i + 1)); end
            pop_byte();
            idle(2);
            exp_lvl = 3'(3 - i);
            n_tests++; if (uart_rts !== (exp_lvl >= 3'd3)) begin n_fail++; $display("FAIL ovr_drain_rts[%0d] got=%b exp=%b", i, uart_rts, exp_lvl >= 3'd3); end
        end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty got=%b exp=0", rx_valid); end
        pulse_clear();
        n_tests++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got=%b exp=0", err_overrun); end
    endtask

    task automatic test_glitch();
        @(negedge clk);
        uart_rxd = 1'b0;
        idle(2);
        uart_rxd = 1'b1;
        idle(3 * BIT_CYC);
        n_tests++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL glitch_state got=%0d exp=0", dbg_state); end
        n_tests++; if (rx_level !== 3'd0) begin n_fail++; $display("FAIL glitch_level got=%0d exp=0", rx_level); end
        n_tests++; if ({err_frame, err_overrun} !== 2'b00) begin n_fail++; $display("FAIL glitch_err got=%b exp=00", {err_frame, err_overrun}); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            send_frame(8'(8'h10 + i), 1'b0, 1'b0, 1, 1'b1);
            idle(4);
        end
        // 8N1 at div=15: stop mid-bit sample (push) lands on the 155th rising
        // edge after the start bit is driven, so rx_read covers exactly that edge.
        fork
            send_frame(8'h14, 1'b0, 1'b0, 1, 1'b1);
            begin
                repeat (155) @(negedge clk);
                rx_read = 1'b1;
                @(negedge clk);
                rx_read = 1'b0;
            end
        join
        idle(4);
        n_tests++; if (rx_level !== 3'd4) begin n_fail++; $display("FAIL b2b_level got=%0d exp=4", rx_level); end
        n_tests++; if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got=%b exp=0", err_overrun); end
        for (int i = 0; i < 4; i++) begin
            n_tests++; if (rx_data !== 8'(8'h11 + i)) begin n_fail++; $display("FAIL b2b_pop[%0d] got=%h exp=%h", i, rx_data, 8'(8'h11 + i)); end
            pop_byte();
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h21, 1'b0, 1'b0, 1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        @(negedge clk);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        resetn = 1'b0;
        uart_rxd = 1'b1;
        idle(2);
        n_tests++; if (rx_level !== 3'd0 || rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_level got=%0d/%b exp=0/0", rx_level, rx_valid); end
        n_tests++; if (uart_rts !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rts got=%b exp=1", uart_rts); end
        n_tests++; if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL rst_mid_state got=%0d exp=0", dbg_state); end
        resetn = 1'b1;
        idle(2 * BIT_CYC);
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b1);
        idle(4);
        n_tests++; if (rx_data !== 8'h3C || rx_level !== 3'd1) begin n_fail++; $display("FAIL rst_mid_next got=%h/%0d exp=3c/1", rx_data, rx_level); end
        n_tests++; if ({err_frame, err_overrun, rx_parity_err} !== 3'b000) begin n_fail++; $display("FAIL rst_mid_err got=%b exp=000", {err_frame, err_overrun, rx_parity_err}); end
        pop_byte();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_frame_break();
        test_overrun();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
